// File: rtl/cam_mon_pkg.sv
// Shared types for the CAM transaction monitor: record kinds and the packed record layout.
package cam_mon_pkg;

  localparam int KEY_W_DEF = 16;
  localparam int VAL_W_DEF = 16;
  localparam int TS_W_DEF  = 32;

  typedef enum logic [1:0] {
    TR_RESET = 2'd0,
    TR_READ  = 2'd1,
    TR_WRITE = 2'd2
  } tr_type_e;

  // Default-width record; the top rebuilds the same layout from its own parameters.
  typedef struct packed {
    tr_type_e               tr_type;
    logic [TS_W_DEF-1:0]    ltime;
    logic [KEY_W_DEF-1:0]   key;
    logic [VAL_W_DEF-1:0]   wdata;
    logic [VAL_W_DEF-1:0]   rdata;
    logic                   hit;
  } mon_rec_t;

endpackage

// File: rtl/cam_tr_monitor_if.sv
// Bundle of the observed CAM bus and the record stream toward the scoreboard.
interface cam_tr_monitor_if #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) ();
  import cam_mon_pkg::*;

  logic                       cam_rst_i;
  logic                       cam_valid_i;
  logic                       cam_rw_n_i;
  logic [KEY_W-1:0]           cam_key_i;
  logic [VAL_W-1:0]           cam_val_i;
  logic [VAL_W-1:0]           cam_val_o;
  logic                       cam_valid_o;

  logic                       tr_valid_o;
  logic                       tr_ready_i;
  tr_type_e                   tr_type_o;
  logic [TS_W-1:0]            tr_ltime_o;
  logic [KEY_W-1:0]           tr_key_o;
  logic [VAL_W-1:0]           tr_wdata_o;
  logic [VAL_W-1:0]           tr_rdata_o;
  logic                       tr_hit_o;
  logic                       overflow_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;

  modport master (
    output cam_rst_i, cam_valid_i, cam_rw_n_i, cam_key_i, cam_val_i, cam_val_o, cam_valid_o,
    output tr_ready_i,
    input  tr_valid_o, tr_type_o, tr_ltime_o, tr_key_o, tr_wdata_o, tr_rdata_o, tr_hit_o,
    input  overflow_o, count_o
  );

  modport slave (
    input  cam_rst_i, cam_valid_i, cam_rw_n_i, cam_key_i, cam_val_i, cam_val_o, cam_valid_o,
    input  tr_ready_i,
    output tr_valid_o, tr_type_o, tr_ltime_o, tr_key_o, tr_wdata_o, tr_rdata_o, tr_hit_o,
    output overflow_o, count_o
  );

endinterface

// File: rtl/cam_mon_fifo.sv
// Synchronous record FIFO: push/full on the write side, valid/ready on the read side.
module cam_mon_fifo
  import cam_mon_pkg::*;
#(
  parameter type rec_t = mon_rec_t,
  parameter int  DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  rec_t                       push_data,
  output logic                       full,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output rec_t                       rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             pop;
  logic             wr_en;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop      = rd_valid & rd_ready;
  assign wr_en    = push & (~full | pop);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign rd_valid = (cnt != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cam_tr_monitor.sv
// Time-stamps CAM requests/resets, delays them to the DUT read latency so read data can be
// attached in order, and queues one record per event for the scoreboard.
module cam_tr_monitor
  import cam_mon_pkg::*;
#(
  parameter int KEY_W  = 16,
  parameter int VAL_W  = 16,
  parameter int TS_W   = 32,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  cam_tr_monitor_if.slave bus
);

  typedef struct packed {
    tr_type_e         tr_type;
    logic [TS_W-1:0]  ltime;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] wdata;
    logic [VAL_W-1:0] rdata;
    logic             hit;
  } rec_t;

  typedef struct packed {
    logic             valid;
    tr_type_e         tr_type;
    logic [TS_W-1:0]  ltime;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] wdata;
  } stage_t;

  logic [TS_W-1:0] ts;
  logic            cam_rst_q;
  logic            rst_event;
  logic            rd_event;
  logic            wr_event;
  stage_t          new_entry;
  stage_t          pipe [RD_LAT];
  stage_t          pipe_out;
  rec_t            push_rec;
  logic            push;
  logic            fifo_full;
  logic            fifo_valid;
  rec_t            head;
  logic            overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      cam_rst_q <= 1'b0;
    end else begin
      ts        <= ts + TS_W'(1);
      cam_rst_q <= bus.cam_rst_i;
    end
  end

  // Only the rising edge of the DUT reset is an event; requests are ignored while it is held.
  always_comb begin
    rst_event = bus.cam_rst_i & ~cam_rst_q;
    rd_event  = bus.cam_valid_i & bus.cam_rw_n_i & ~bus.cam_rst_i;
    wr_event  = bus.cam_valid_i & ~bus.cam_rw_n_i & ~bus.cam_rst_i;
    new_entry       = '0;
    new_entry.ltime = ts;
    if (rst_event) begin
      new_entry.valid   = 1'b1;
      new_entry.tr_type = TR_RESET;
    end else if (rd_event) begin
      new_entry.valid   = 1'b1;
      new_entry.tr_type = TR_READ;
      new_entry.key     = bus.cam_key_i;
    end else if (wr_event) begin
      new_entry.valid   = 1'b1;
      new_entry.tr_type = TR_WRITE;
      new_entry.key     = bus.cam_key_i;
      new_entry.wdata   = bus.cam_val_i;
    end
  end

  // A reset event kills everything already in flight but itself enters stage 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= new_entry;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i]       <= pipe[i-1];
        pipe[i].valid <= pipe[i-1].valid & ~rst_event;
      end
    end
  end

  assign pipe_out = pipe[RD_LAT-1];
  assign push     = pipe_out.valid & ~rst_event;

  always_comb begin
    push_rec         = '0;
    push_rec.tr_type = pipe_out.tr_type;
    push_rec.ltime   = pipe_out.ltime;
    push_rec.key     = pipe_out.key;
    push_rec.wdata   = pipe_out.wdata;
    if (pipe_out.tr_type == TR_READ) begin
      push_rec.rdata = bus.cam_val_o;
      push_rec.hit   = bus.cam_valid_o;
    end
  end

  cam_mon_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_rec),
    .full      (fifo_full),
    .rd_valid  (fifo_valid),
    .rd_ready  (bus.tr_ready_i),
    .rd_data   (head),
    .count     (bus.count_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push & fifo_full & ~(fifo_valid & bus.tr_ready_i)) begin
      overflow <= 1'b1;
    end
  end

  assign bus.tr_valid_o = fifo_valid;
  assign bus.tr_type_o  = head.tr_type;
  assign bus.tr_ltime_o = head.ltime;
  assign bus.tr_key_o   = head.key;
  assign bus.tr_wdata_o = head.wdata;
  assign bus.tr_rdata_o = head.rdata;
  assign bus.tr_hit_o   = head.hit;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_cam_tr_monitor.sv
// Directed bench for cam_tr_monitor: a per-cycle vector table on an RD_LAT=1 instance,
// plus hand sequences for squash (RD_LAT=2), overflow and full-FIFO pop/push with async reset.
module tb_cam_tr_monitor;
  import cam_mon_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cam_tr_monitor_if bus1 ();
  cam_tr_monitor_if bus2 ();

  cam_tr_monitor #(.RD_LAT(1), .DEPTH(8)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  cam_tr_monitor #(.RD_LAT(2), .DEPTH(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, vld, rw;
    logic [15:0] key, wd, rv;
    logic        rh, rdy;
    logic        ev;
    tr_type_e    et;
    logic [31:0] elt;
    logic [15:0] ek, ewd, erd;
    logic        eh;
    logic [3:0]  ecnt;
    logic        eovf;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic rst, logic vld, logic rw, logic [15:0] key, logic [15:0] wd,
                              logic [15:0] rv, logic rh, logic rdy, logic ev, tr_type_e et,
                              logic [31:0] elt, logic [15:0] ek, logic [15:0] ewd,
                              logic [15:0] erd, logic eh, logic [3:0] ecnt, logic eovf);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rw = rw; v.key = key; v.wd = wd; v.rv = rv; v.rh = rh;
    v.rdy = rdy; v.ev = ev; v.et = et; v.elt = elt; v.ek = ek; v.ewd = ewd; v.erd = erd;
    v.eh = eh; v.ecnt = ecnt; v.eovf = eovf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    bus1.cam_rst_i = 0; bus1.cam_valid_i = 0; bus1.cam_rw_n_i = 0; bus1.cam_key_i = 0;
    bus1.cam_val_i = 0; bus1.cam_val_o = 0; bus1.cam_valid_o = 0; bus1.tr_ready_i = 1;
    bus2.cam_rst_i = 0; bus2.cam_valid_i = 0; bus2.cam_rw_n_i = 0; bus2.cam_key_i = 0;
    bus2.cam_val_i = 0; bus2.cam_val_o = 0; bus2.cam_valid_o = 0; bus2.tr_ready_i = 1;
  endtask

  // Leaves the bench at the falling edge that starts cycle 0 (ts = 0).
  task automatic resetDut();
    idleInputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus1.cam_rst_i   = v.rst;
    bus1.cam_valid_i = v.vld;
    bus1.cam_rw_n_i  = v.rw;
    bus1.cam_key_i   = v.key;
    bus1.cam_val_i   = v.wd;
    bus1.cam_val_o   = v.rv;
    bus1.cam_valid_o = v.rh;
    bus1.tr_ready_i  = v.rdy;
  endtask

  task automatic checkVec(input int c, input vec_t v);
    checkOutput($sformatf("tbl c%0d valid", c), 32'(bus1.tr_valid_o), 32'(v.ev));
    checkOutput($sformatf("tbl c%0d count", c), 32'(bus1.count_o), 32'(v.ecnt));
    checkOutput($sformatf("tbl c%0d overflow", c), 32'(bus1.overflow_o), 32'(v.eovf));
    if (v.ev) begin
      checkOutput($sformatf("tbl c%0d type", c), 32'(bus1.tr_type_o), 32'(v.et));
      checkOutput($sformatf("tbl c%0d ltime", c), bus1.tr_ltime_o, v.elt);
      checkOutput($sformatf("tbl c%0d key", c), 32'(bus1.tr_key_o), 32'(v.ek));
      checkOutput($sformatf("tbl c%0d wdata", c), 32'(bus1.tr_wdata_o), 32'(v.ewd));
      checkOutput($sformatf("tbl c%0d rdata", c), 32'(bus1.tr_rdata_o), 32'(v.erd));
      checkOutput($sformatf("tbl c%0d hit", c), 32'(bus1.tr_hit_o), 32'(v.eh));
    end
  endtask

  task automatic checkAllZero1(input string tag);
    checkOutput({tag, " valid"}, 32'(bus1.tr_valid_o), 0);
    checkOutput({tag, " type"}, 32'(bus1.tr_type_o), 0);
    checkOutput({tag, " ltime"}, bus1.tr_ltime_o, 0);
    checkOutput({tag, " key"}, 32'(bus1.tr_key_o), 0);
    checkOutput({tag, " wdata"}, 32'(bus1.tr_wdata_o), 0);
    checkOutput({tag, " rdata"}, 32'(bus1.tr_rdata_o), 0);
    checkOutput({tag, " hit"}, 32'(bus1.tr_hit_o), 0);
    checkOutput({tag, " overflow"}, 32'(bus1.overflow_o), 0);
    checkOutput({tag, " count"}, 32'(bus1.count_o), 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    //            rst vld rw key     wd       rv       rh rdy  ev et        elt ek      ewd      erd      eh cnt ovf
    tbl[0]  = mk(0, 0, 0, 0,      0,       0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = mk(0, 1, 0, 'h12,   'hBEEF,  0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[4]  = tbl[0];
    tbl[5]  = mk(0, 1, 0, 'h40,   'h1234,  0,       0, 1,   1, TR_WRITE, 3,  'h12,   'hBEEF,  0,       0, 1, 0);
    tbl[6]  = mk(0, 1, 1, 'h40,   0,       0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0,      0,       'h1234,  1, 1,   1, TR_WRITE, 5,  'h40,   'h1234,  0,       0, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0,      0,       0,       0, 1,   1, TR_READ,  6,  'h40,   0,       'h1234,  1, 1, 0);
    tbl[9]  = tbl[0];
    tbl[10] = mk(1, 1, 1, 'h55,   0,       0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[11] = mk(1, 1, 0, 'h66,   'h77,    0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[12] = mk(1, 1, 1, 'h55,   0,       0,       0, 1,   1, TR_RESET, 10, 0,      0,       0,       0, 1, 0);
    tbl[13] = tbl[0];
    tbl[14] = mk(0, 1, 1, 'h77,   0,       0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,      0,       'hAAAA,  0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0,      0,       0,       0, 0,   1, TR_READ,  14, 'h77,   0,       'hAAAA,  0, 1, 0);
    tbl[17] = mk(0, 0, 0, 0,      0,       0,       0, 1,   1, TR_READ,  14, 'h77,   0,       'hAAAA,  0, 1, 0);
    tbl[18] = mk(0, 1, 0, 'h1,    'h0101,  0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[19] = mk(0, 1, 0, 'h2,    'h0202,  0,       0, 1,   0, TR_RESET, 0,  0,      0,       0,       0, 0, 0);
    tbl[20] = mk(0, 1, 1, 'h3,    0,       0,       0, 1,   1, TR_WRITE, 18, 'h1,    'h0101,  0,       0, 1, 0);
    tbl[21] = mk(0, 0, 0, 0,      0,       'h3333,  1, 1,   1, TR_WRITE, 19, 'h2,    'h0202,  0,       0, 1, 0);
    tbl[22] = mk(0, 0, 0, 0,      0,       0,       0, 1,   1, TR_READ,  20, 'h3,    0,       'h3333,  1, 1, 0);
    tbl[23] = tbl[0];

    resetDut();
    checkAllZero1("reset");

    for (int c = 0; c < 24; c++) begin
      checkVec(c, tbl[c]);
      applyStimulus(tbl[c]);
      @(negedge clk);
    end

    // Squash on the RD_LAT=2 instance: a read in flight is killed by the reset edge.
    resetDut();
    for (int c = 0; c < 15; c++) begin
      checkOutput($sformatf("sq c%0d overflow", c), 32'(bus2.overflow_o), 0);
      case (c)
        6, 7, 9, 14: checkOutput($sformatf("sq c%0d valid", c), 32'(bus2.tr_valid_o), 0);
        8: begin
          checkOutput("sq c8 valid", 32'(bus2.tr_valid_o), 1);
          checkOutput("sq c8 type", 32'(bus2.tr_type_o), 32'(TR_RESET));
          checkOutput("sq c8 ltime", bus2.tr_ltime_o, 5);
          checkOutput("sq c8 key", 32'(bus2.tr_key_o), 0);
          checkOutput("sq c8 count", 32'(bus2.count_o), 1);
        end
        13: begin
          checkOutput("lat2 c13 valid", 32'(bus2.tr_valid_o), 1);
          checkOutput("lat2 c13 type", 32'(bus2.tr_type_o), 32'(TR_READ));
          checkOutput("lat2 c13 ltime", bus2.tr_ltime_o, 10);
          checkOutput("lat2 c13 key", 32'(bus2.tr_key_o), 'hA1);
          checkOutput("lat2 c13 rdata", 32'(bus2.tr_rdata_o), 'h2222);
          checkOutput("lat2 c13 hit", 32'(bus2.tr_hit_o), 1);
        end
        default: ;
      endcase
      idleInputs();
      case (c)
        4:  begin bus2.cam_valid_i = 1; bus2.cam_rw_n_i = 1; bus2.cam_key_i = 'h99; end
        5:  bus2.cam_rst_i = 1;
        6:  begin bus2.cam_val_o = 'h9999; bus2.cam_valid_o = 1; end
        10: begin bus2.cam_valid_i = 1; bus2.cam_rw_n_i = 1; bus2.cam_key_i = 'hA1; end
        11: begin bus2.cam_val_o = 'h1111; bus2.cam_valid_o = 0; end
        12: begin bus2.cam_val_o = 'h2222; bus2.cam_valid_o = 1; end
        default: ;
      endcase
      @(negedge clk);
    end

    // Overflow: ten writes with the consumer stalled, then drain.
    resetDut();
    for (int c = 0; c < 22; c++) begin
      checkOutput($sformatf("ovf c%0d overflow", c), 32'(bus1.overflow_o), 32'(c >= 12));
      if (c <= 12)
        checkOutput($sformatf("ovf c%0d count", c), 32'(bus1.count_o),
                    (c < 4) ? 0 : ((c - 3 > 8) ? 8 : c - 3));
      if (c >= 13 && c <= 20) begin
        checkOutput($sformatf("drain c%0d valid", c), 32'(bus1.tr_valid_o), 1);
        checkOutput($sformatf("drain c%0d type", c), 32'(bus1.tr_type_o), 32'(TR_WRITE));
        checkOutput($sformatf("drain c%0d key", c), 32'(bus1.tr_key_o), c - 12);
        checkOutput($sformatf("drain c%0d ltime", c), bus1.tr_ltime_o, c - 11);
        checkOutput($sformatf("drain c%0d wdata", c), 32'(bus1.tr_wdata_o), 'h1000 + c - 12);
        checkOutput($sformatf("drain c%0d count", c), 32'(bus1.count_o), 21 - c);
      end
      if (c == 21) begin
        checkOutput("drain c21 valid", 32'(bus1.tr_valid_o), 0);
        checkOutput("drain c21 count", 32'(bus1.count_o), 0);
      end
      idleInputs();
      bus1.tr_ready_i = (c >= 13);
      if (c >= 2 && c <= 11) begin
        bus1.cam_valid_i = 1;
        bus1.cam_key_i   = 16'(c - 1);
        bus1.cam_val_i   = 16'('h1000 + c - 1);
      end
      @(negedge clk);
    end

    // Full FIFO with pop and push in the same cycle, then rst_n mid-stream.
    resetDut();
    checkOutput("sticky cleared overflow", 32'(bus1.overflow_o), 0);
    for (int c = 0; c < 16; c++) begin
      if (c == 9) checkOutput("full c9 count", 32'(bus1.count_o), 7);
      if (c >= 10) begin
        checkOutput($sformatf("full c%0d count", c), 32'(bus1.count_o), 8);
        checkOutput($sformatf("full c%0d overflow", c), 32'(bus1.overflow_o), 0);
        checkOutput($sformatf("full c%0d key", c), 32'(bus1.tr_key_o), 'h21 + c - 10);
      end
      idleInputs();
      bus1.tr_ready_i = (c >= 10);
      if (c >= 1) begin
        bus1.cam_valid_i = 1;
        bus1.cam_key_i   = 16'('h20 + c);
        bus1.cam_val_i   = 16'('h2000 + c);
      end
      if (c == 15) begin
        #2 rst_n = 1'b0;
        #1 checkAllZero1("async rst");
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
